// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, the writeback FIFO entry layout and value-shaping helpers
// for the writeback arbiter.
package writeback_arbiter_pkg;

  localparam int unsigned VLEN          = 128;
  localparam int unsigned XLEN          = 64;
  localparam int unsigned REG_WID       = 6;
  localparam int unsigned SB_SIZE_WID   = 4;
  localparam int unsigned WB_FIFO_DEPTH = 2;

  // One completed result waiting for writeback.
  typedef struct packed {
    logic [SB_SIZE_WID-1:0] pos;
    logic [REG_WID-1:0]     rd;
    logic [VLEN-1:0]        value;
  } wb_entry_t;

  localparam int unsigned WB_ENTRY_WID = $bits(wb_entry_t);

  // The top bit of rd selects the vector register file.
  function automatic logic wb_is_vector(input logic [REG_WID-1:0] rd);
    return rd[REG_WID-1];
  endfunction

  // Scalar results only carry XLEN meaningful bits; clear the rest.
  function automatic logic [VLEN-1:0] wb_shape_value(input logic [REG_WID-1:0] rd,
                                                     input logic [VLEN-1:0]    value);
    if (wb_is_vector(rd)) begin
      return value;
    end
    return {{(VLEN-XLEN){1'b0}}, value[XLEN-1:0]};
  endfunction

  // Scalar x0 is hardwired to zero, so it never gets a register write.
  function automatic logic wb_writes_reg(input logic [REG_WID-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with wrapping pointers; depth must be a power of two.
// Only pointers and count are reset; the storage array is not.
module wb_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push_c;
  logic              do_pop_c;

  // Status comes from the count register only, so a same-cycle pop never frees space.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign dout      = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load/store results into one registered writeback/commit
// stream, round-robin between the two source FIFOs.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_res_valid,
  output logic                   alu_res_ready,
  input  logic [SB_SIZE_WID-1:0] alu_res_pos,
  input  logic [REG_WID-1:0]     alu_res_rd,
  input  logic [VLEN-1:0]        alu_res_value,
  input  logic                   ls_res_valid,
  output logic                   ls_res_ready,
  input  logic [SB_SIZE_WID-1:0] ls_res_pos,
  input  logic [REG_WID-1:0]     ls_res_rd,
  input  logic [VLEN-1:0]        ls_res_value,
  output logic                   wb_valid,
  output logic [REG_WID-1:0]     wb_rd,
  output logic [VLEN-1:0]        wb_value,
  output logic                   cm_valid,
  output logic [SB_SIZE_WID-1:0] cm_pos
);

  wb_entry_t alu_din_c;
  wb_entry_t ls_din_c;
  wb_entry_t alu_dout_c;
  wb_entry_t ls_dout_c;
  wb_entry_t win_c;
  logic      alu_full_c;
  logic      ls_full_c;
  logic      alu_empty_c;
  logic      ls_empty_c;
  logic      grant_alu_c;
  logic      grant_ls_c;
  logic      grant_any_c;
  logic      last_ls;

  assign alu_din_c     = '{pos: alu_res_pos, rd: alu_res_rd, value: alu_res_value};
  assign ls_din_c      = '{pos: ls_res_pos,  rd: ls_res_rd,  value: ls_res_value};
  assign alu_res_ready = !alu_full_c;
  assign ls_res_ready  = !ls_full_c;

  wb_fifo #(
    .DATA_W (WB_ENTRY_WID),
    .DEPTH  (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (alu_res_valid),
    .din   (alu_din_c),
    .full  (alu_full_c),
    .pop   (grant_alu_c),
    .dout  (alu_dout_c),
    .empty (alu_empty_c)
  );

  wb_fifo #(
    .DATA_W (WB_ENTRY_WID),
    .DEPTH  (FIFO_DEPTH)
  ) u_ls_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ls_res_valid),
    .din   (ls_din_c),
    .full  (ls_full_c),
    .pop   (grant_ls_c),
    .dout  (ls_dout_c),
    .empty (ls_empty_c)
  );

  // Pick one non-empty FIFO; on a tie, serve the source not granted last.
  always_comb begin
    grant_alu_c = 1'b0;
    grant_ls_c  = 1'b0;
    if (!alu_empty_c && !ls_empty_c) begin
      if (last_ls) grant_alu_c = 1'b1;
      else         grant_ls_c  = 1'b1;
    end else if (!alu_empty_c) begin
      grant_alu_c = 1'b1;
    end else if (!ls_empty_c) begin
      grant_ls_c = 1'b1;
    end
    grant_any_c = grant_alu_c || grant_ls_c;
    win_c       = grant_ls_c ? ls_dout_c : alu_dout_c;
  end

  // Register the winning entry; data outputs hold when nothing is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_value <= '0;
      cm_valid <= 1'b0;
      cm_pos   <= '0;
      last_ls  <= 1'b1;
    end else begin
      cm_valid <= grant_any_c;
      wb_valid <= grant_any_c && wb_writes_reg(win_c.rd);
      if (grant_any_c) begin
        cm_pos   <= win_c.pos;
        wb_rd    <= win_c.rd;
        wb_value <= wb_shape_value(win_c.rd, win_c.value);
        last_ls  <= grant_ls_c;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a queue-based reference model is
// updated at every rising edge and compared with the DUT on every falling edge.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   alu_res_valid = 1'b0;
  logic                   alu_res_ready;
  logic [SB_SIZE_WID-1:0] alu_res_pos = '0;
  logic [REG_WID-1:0]     alu_res_rd = '0;
  logic [VLEN-1:0]        alu_res_value = '0;
  logic                   ls_res_valid = 1'b0;
  logic                   ls_res_ready;
  logic [SB_SIZE_WID-1:0] ls_res_pos = '0;
  logic [REG_WID-1:0]     ls_res_rd = '0;
  logic [VLEN-1:0]        ls_res_value = '0;
  logic                   wb_valid;
  logic [REG_WID-1:0]     wb_rd;
  logic [VLEN-1:0]        wb_value;
  logic                   cm_valid;
  logic [SB_SIZE_WID-1:0] cm_pos;

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_res_valid (alu_res_valid),
    .alu_res_ready (alu_res_ready),
    .alu_res_pos   (alu_res_pos),
    .alu_res_rd    (alu_res_rd),
    .alu_res_value (alu_res_value),
    .ls_res_valid  (ls_res_valid),
    .ls_res_ready  (ls_res_ready),
    .ls_res_pos    (ls_res_pos),
    .ls_res_rd     (ls_res_rd),
    .ls_res_value  (ls_res_value),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_value      (wb_value),
    .cm_valid      (cm_valid),
    .cm_pos        (cm_pos)
  );

  int errors = 0;
  int checks = 0;

  // Pending offers from each source, and the model's view of each FIFO.
  wb_entry_t a_src[$];
  wb_entry_t l_src[$];
  wb_entry_t m_aq[$];
  wb_entry_t m_lq[$];
  logic      m_last_ls = 1'b1;

  logic                   e_wb_valid = 1'b0;
  logic                   e_cm_valid = 1'b0;
  logic [REG_WID-1:0]     e_wb_rd = '0;
  logic [VLEN-1:0]        e_wb_value = '0;
  logic [SB_SIZE_WID-1:0] e_cm_pos = '0;
  logic [SB_SIZE_WID-1:0] commit_log[$];

  function automatic wb_entry_t mk(input logic [SB_SIZE_WID-1:0] pos,
                                   input logic [REG_WID-1:0]     rd,
                                   input logic [VLEN-1:0]        value);
    wb_entry_t e;
    e.pos   = pos;
    e.rd    = rd;
    e.value = value;
    return e;
  endfunction

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present the head of each source queue, holding it until accepted.
  task automatic drive();
    alu_res_valid = (a_src.size() > 0);
    alu_res_pos   = '0;
    alu_res_rd    = '0;
    alu_res_value = '0;
    if (a_src.size() > 0) begin
      alu_res_pos   = a_src[0].pos;
      alu_res_rd    = a_src[0].rd;
      alu_res_value = a_src[0].value;
    end
    ls_res_valid = (l_src.size() > 0);
    ls_res_pos   = '0;
    ls_res_rd    = '0;
    ls_res_value = '0;
    if (l_src.size() > 0) begin
      ls_res_pos   = l_src[0].pos;
      ls_res_rd    = l_src[0].rd;
      ls_res_value = l_src[0].value;
    end
  endtask

  // Reference behaviour at a rising edge: pop (round-robin on tie), then accept pushes.
  task automatic model_edge();
    logic      acc_a;
    logic      acc_l;
    logic      take_ls;
    wb_entry_t e;
    acc_a = alu_res_valid && (m_aq.size() < DEPTH);
    acc_l = ls_res_valid && (m_lq.size() < DEPTH);
    if (m_aq.size() > 0 || m_lq.size() > 0) begin
      take_ls    = (m_lq.size() > 0) && (m_aq.size() == 0 || !m_last_ls);
      e          = take_ls ? m_lq.pop_front() : m_aq.pop_front();
      m_last_ls  = take_ls;
      e_cm_valid = 1'b1;
      e_cm_pos   = e.pos;
      e_wb_rd    = e.rd;
      e_wb_valid = (e.rd != 6'd0);
      if (e.rd >= 6'd32) e_wb_value = e.value;
      else               e_wb_value = e.value & {{(VLEN-XLEN){1'b0}}, {XLEN{1'b1}}};
    end else begin
      e_cm_valid = 1'b0;
      e_wb_valid = 1'b0;
    end
    if (acc_a) m_aq.push_back(a_src.pop_front());
    if (acc_l) m_lq.push_back(l_src.pop_front());
  endtask

  task automatic compare();
    chk("alu_res_ready", VLEN'(alu_res_ready), VLEN'(m_aq.size() < DEPTH));
    chk("ls_res_ready",  VLEN'(ls_res_ready),  VLEN'(m_lq.size() < DEPTH));
    chk("wb_valid",      VLEN'(wb_valid),      VLEN'(e_wb_valid));
    chk("cm_valid",      VLEN'(cm_valid),      VLEN'(e_cm_valid));
    chk("cm_pos",        VLEN'(cm_pos),        VLEN'(e_cm_pos));
    chk("wb_rd",         VLEN'(wb_rd),         VLEN'(e_wb_rd));
    chk("wb_value",      wb_value,             e_wb_value);
  endtask

  task automatic cycle();
    drive();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    if (cm_valid) commit_log.push_back(cm_pos);
  endtask

  // Assert reset away from a clock edge, check the immediate clear, release later.
  task automatic apply_reset();
    rst_n = 1'b0;
    a_src.delete();
    l_src.delete();
    m_aq.delete();
    m_lq.delete();
    m_last_ls  = 1'b1;
    e_wb_valid = 1'b0;
    e_cm_valid = 1'b0;
    e_wb_rd    = '0;
    e_wb_value = '0;
    e_cm_pos   = '0;
    drive();
    #1;
    compare();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while ((a_src.size() + l_src.size() + m_aq.size() + m_lq.size()) > 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
    cycle();
  endtask

  initial begin
    // Reset state
    apply_reset();
    chk("rst_wb_valid",  VLEN'(wb_valid),      VLEN'(0));
    chk("rst_cm_valid",  VLEN'(cm_valid),      VLEN'(0));
    chk("rst_alu_ready", VLEN'(alu_res_ready), VLEN'(1));
    chk("rst_ls_ready",  VLEN'(ls_res_ready),  VLEN'(1));

    // Single vector ALU result: one-cycle latency, one-cycle pulse
    a_src.push_back(mk(4'd3, 6'h21, {16{8'hAA}}));
    cycle();
    chk("single_before", VLEN'(cm_valid), VLEN'(0));
    cycle();
    chk("single_wb_valid", VLEN'(wb_valid), VLEN'(1));
    chk("single_cm_valid", VLEN'(cm_valid), VLEN'(1));
    chk("single_wb_rd",    VLEN'(wb_rd),    VLEN'(6'h21));
    chk("single_cm_pos",   VLEN'(cm_pos),   VLEN'(3));
    chk("single_wb_value", wb_value,        {16{8'hAA}});
    cycle();
    chk("single_pulse_end", VLEN'(wb_valid), VLEN'(0));
    chk("single_hold",      wb_value,        {16{8'hAA}});

    // Scalar LS write: upper bits cleared
    l_src.push_back(mk(4'd5, 6'h05, {VLEN{1'b1}}));
    cycle();
    cycle();
    chk("scalar_wb_valid", VLEN'(wb_valid), VLEN'(1));
    chk("scalar_wb_value", wb_value, 128'h0000000000000000_FFFFFFFFFFFFFFFF);

    // Scalar x0: commit without register write
    l_src.push_back(mk(4'd6, 6'h00, 128'h1234));
    cycle();
    cycle();
    chk("x0_wb_valid", VLEN'(wb_valid), VLEN'(0));
    chk("x0_cm_valid", VLEN'(cm_valid), VLEN'(1));
    chk("x0_cm_pos",   VLEN'(cm_pos),   VLEN'(6));
    cycle();

    // Both sources saturated: alternation, ALU first, ALU FIFO backpressure
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      a_src.push_back(mk(SB_SIZE_WID'(i),     6'h21, VLEN'(i * 17)));
      l_src.push_back(mk(SB_SIZE_WID'(8 + i), 6'h02, VLEN'(100 + i)));
    end
    commit_log.delete();
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k == 2) chk("bp_alu_full",    VLEN'(alu_res_ready), VLEN'(0));
      if (k == 3) chk("bp_ready_back",  VLEN'(alu_res_ready), VLEN'(1));
      if (k == 3) chk("bp_held_offer",  VLEN'(a_src[0].pos),  VLEN'(3));
    end
    run_until_idle(60);
    chk("rr_count", VLEN'(commit_log.size()), VLEN'(16));
    for (int i = 0; i < 16 && i < commit_log.size(); i++) begin
      chk("rr_order", VLEN'(commit_log[i]), VLEN'((i % 2 == 0) ? (i / 2) : (8 + i / 2)));
    end

    // Mid-stream reset with three entries queued
    apply_reset();
    a_src.push_back(mk(4'd1, 6'h22, VLEN'(11)));
    a_src.push_back(mk(4'd2, 6'h23, VLEN'(12)));
    l_src.push_back(mk(4'd9, 6'h03, VLEN'(13)));
    l_src.push_back(mk(4'd10, 6'h04, VLEN'(14)));
    cycle();
    cycle();
    chk("pre_rst_queued", VLEN'(m_aq.size() + m_lq.size()), VLEN'(3));
    chk("pre_rst_cm_valid", VLEN'(cm_valid), VLEN'(1));
    apply_reset();
    chk("mid_rst_cm_valid",  VLEN'(cm_valid),      VLEN'(0));
    chk("mid_rst_wb_value",  wb_value,             VLEN'(0));
    chk("mid_rst_alu_ready", VLEN'(alu_res_ready), VLEN'(1));
    chk("mid_rst_ls_ready",  VLEN'(ls_res_ready),  VLEN'(1));
    commit_log.delete();
    for (int k = 0; k < 4; k++) cycle();
    chk("no_stale_commit", VLEN'(commit_log.size()), VLEN'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
